mc_cpu: RTL and testbench

Multi-cycle successor to the single-cycle MIPS-subset CPU. One shared instruction/data memory port with a ready handshake tolerates wait states. Datapath width, register count and reset vector are parametrised. Adds halt/illegal status and cycle/retire counters for bench visibility, and sits at the top of the core in place of the single-cycle CPU.

---
 rtl/mc_cpu_pkg.sv | 33 +++
 rtl/mc_regfile.sv | 30 +++
 rtl/mc_cpu.sv | 198 +++++++++++++++++++
 tb/tb_mc_cpu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared encodings and enums for the multi-cycle MIPS-subset core.
package mc_cpu_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpHlt   = 6'b111111;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    logic ok;
    case (op)
      OpRtype: ok = (fn == FnAdd) || (fn == FnSub) || (fn == FnAnd) || (fn == FnOr) ||
                    (fn == FnSlt);
      OpAddi, OpLw, OpSw, OpBeq, OpJ, OpHlt: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x XLEN register file: two combinational reads, one synchronous write, r0 fixed at zero.
module mc_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [$clog2(NREG)-1:0] raddr_a_i,
  input  logic [$clog2(NREG)-1:0] raddr_b_i,
  output logic [XLEN-1:0]         rdata_a_o,
  output logic [XLEN-1:0]         rdata_b_o,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [XLEN-1:0]         wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core with one shared memory port (req/ready), halt status and counters.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic            illegal,
  output logic            retired,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  localparam int unsigned RW = $clog2(NREG);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [XLEN-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d, sw_done_q, sw_done_d, exec_retire;

  logic [5:0]      op, funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] imm, rf_a, rf_b, alu_opnd, alu_res;
  alu_op_e         alu_op;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign rs    = ir_q[21 +: RW];
  assign rt    = ir_q[16 +: RW];
  assign rd    = ir_q[11 +: RW];
  assign imm   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

  mc_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_rf (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr_a_i(rs),
    .raddr_b_i(rt),
    .rdata_a_o(rf_a),
    .rdata_b_o(rf_b),
    .we_i     (state_q == StWb),
    .waddr_i  ((op == OpRtype) ? rd : rt),
    .wdata_i  ((op == OpLw) ? mdr_q : alu_q)
  );

  always_comb begin
    alu_op = AluAdd;
    if (op == OpRtype) begin
      case (funct)
        FnSub:   alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnSlt:   alu_op = AluSlt;
        default: alu_op = AluAdd;
      endcase
    end
    alu_opnd = (op == OpRtype) ? b_q : imm;
    unique case (alu_op)
      AluSub:  alu_res = a_q - alu_opnd;
      AluAnd:  alu_res = a_q & alu_opnd;
      AluOr:   alu_res = a_q | alu_opnd;
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_opnd))};
      default: alu_res = a_q + alu_opnd;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    illegal_d   = illegal_q;
    sw_done_d   = 1'b0;
    exec_retire = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_q + XLEN'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = rf_a;
        b_d = rf_b;
        if (!is_legal(op, funct)) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (op)
          OpBeq: begin
            if (a_q == b_q) pc_d = pc_q + (imm << 2);
            exec_retire = 1'b1;
            state_d     = StFetch;
          end
          OpJ: begin
            pc_d        = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
            exec_retire = 1'b1;
            state_d     = StFetch;
          end
          OpHlt: begin
            exec_retire = 1'b1;
            state_d     = StHalt;
          end
          OpLw, OpSw: begin
            alu_d   = alu_res;
            state_d = StMem;
          end
          default: begin
            alu_d   = alu_res;
            state_d = StWb;
          end
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (op == OpSw) begin
            sw_done_d = 1'b1;
            state_d   = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Store completion is reported the cycle after ready so no output depends on mem_ready.
  assign retired   = exec_retire | (state_q == StWb) | sw_done_q;
  assign cycle_d   = (state_q != StHalt) ? cycle_q + XLEN'(1) : cycle_q;
  assign instret_d = retired ? instret_q + XLEN'(1) : instret_q;

  always_comb begin
    mem_req   = ~rst & ((state_q == StFetch) | (state_q == StMem));
    mem_we    = mem_req & (state_q == StMem) & (op == OpSw);
    mem_addr  = '0;
    if (mem_req) mem_addr = (state_q == StFetch) ? pc_q : alu_q;
    mem_wdata = mem_we ? b_q : '0;
  end

  assign halted      = (state_q == StHalt);
  assign illegal     = illegal_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      sw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      sw_done_q <= sw_done_d;
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: program table on a 32-bit core plus hand sequences and a 64-bit core.
module tb_mc_cpu;

  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic clk;
  logic rst_a, rst_b;

  logic        mem_req, mem_we, mem_ready, halted, illegal, retired;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, cycle_cnt, instret_cnt;

  logic        req_b, we_b, halted_b, illegal_b, retired_b;
  logic [63:0] addr_b, wdata_b, rdata_b, cyc_b, inst_b;

  logic [31:0] mem   [512];
  logic [31:0] mem_b [64];
  int          wait_n;
  int          wcnt;

  int n_cmp, n_bad;

  mc_cpu #(.XLEN(32), .NREG(32), .RESET_PC(32'h40)) u_dut_a (
    .clk(clk), .rst(rst_a), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .illegal(illegal), .retired(retired), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  mc_cpu #(.XLEN(64), .NREG(16), .RESET_PC(64'h0)) u_dut_b (
    .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(1'b1), .halted(halted_b),
    .illegal(illegal_b), .retired(retired_b), .cycle_cnt(cyc_b), .instret_cnt(inst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with wait_n wait cycles before each ready.
  assign mem_rdata = mem[mem_addr[10:2]];
  assign mem_ready = mem_req && (wcnt == wait_n);
  assign rdata_b   = {32'h0, mem_b[addr_b[7:2]]};

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) wcnt <= 0;
    else if (mem_req) wcnt <= mem_ready ? 0 : wcnt + 1;
  end

  typedef struct packed {
    logic [4:0][31:0] prog;
    logic [4:0]       reg_idx;
    logic [31:0]      reg_val;
    logic             exp_ill;
    logic [7:0]       exp_ir;
    logic [7:0]       exp_cyc;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input logic [4:0] r, input logic [31:0] v, input logic ill,
                              input logic [7:0] ir, input logic [7:0] cyc);
    vec_t t;
    t.prog[0] = p0; t.prog[1] = p1; t.prog[2] = p2; t.prog[3] = p3; t.prog[4] = HLT;
    t.reg_idx = r; t.reg_val = v; t.exp_ill = ill; t.exp_ir = ir; t.exp_cyc = cyc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_a(input vec_t v);
    for (int k = 0; k < 512; k++) mem[k] = 32'h0;
    mem[2]  = 32'hDEAD_BEEF;
    mem[64] = 32'h0000_1234;
    for (int k = 0; k < 5; k++) mem[16 + k] = v.prog[k];
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic run_a(input int budget, input logic hold_chk, output int n_ret,
                       output logic [31:0] first_cyc);
    logic        pend, held_we;
    logic [31:0] held_addr;
    n_ret = 0; first_cyc = '1; pend = 1'b0; held_we = 1'b0; held_addr = '0;
    for (int c = 0; c < budget && !halted; c++) begin
      @(negedge clk);
      if (hold_chk && pend)
        chk("hold_stable", {mem_req, mem_we, mem_addr}, {1'b1, held_we, held_addr});
      pend = mem_req && !mem_ready;
      held_addr = mem_addr;
      held_we = mem_we;
      if (retired) begin
        if (n_ret == 0) first_cyc = cycle_cnt;
        n_ret++;
      end
    end
    if (!halted) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got halted=0, expected halted=1");
    end
  endtask

  initial begin
    int          n_ret, xreq;
    logic [31:0] fcyc;
    vec_t        v;
    n_cmp = 0; n_bad = 0; wait_n = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    #1 rst_a = 1'b1; rst_b = 1'b1;

    vecs[0]  = mk(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'hFFFD),
                  enc_r(1, 2, 3, 6'h20), HLT, 3, 32'd2, 0, 4, 15);
    vecs[1]  = mk(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'hFFFD),
                  enc_r(1, 2, 3, 6'h22), HLT, 3, 32'd8, 0, 4, 15);
    vecs[2]  = mk(enc_i(6'h08, 0, 1, 16'd12), enc_i(6'h08, 0, 2, 16'd10),
                  enc_r(1, 2, 3, 6'h24), HLT, 3, 32'd8, 0, 4, 15);
    vecs[3]  = mk(enc_i(6'h08, 0, 1, 16'd12), enc_i(6'h08, 0, 2, 16'd10),
                  enc_r(1, 2, 3, 6'h25), HLT, 3, 32'd14, 0, 4, 15);
    vecs[4]  = mk(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'hFFFD),
                  enc_r(2, 1, 3, 6'h2A), HLT, 3, 32'd1, 0, 4, 15);
    vecs[5]  = mk(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'hFFFD),
                  enc_r(2, 1, 3, 6'h22), HLT, 3, 32'hFFFF_FFF8, 0, 4, 15);
    vecs[6]  = mk(enc_i(6'h08, 0, 0, 16'd7), enc_i(6'h08, 0, 3, 16'd1), HLT, HLT,
                  3, 32'd1, 0, 3, 11);
    vecs[7]  = mk(enc_i(6'h08, 0, 1, 16'd1), enc_r(1, 1, 2, 6'h07), HLT, HLT,
                  1, 32'd1, 1, 1, 6);
    vecs[8]  = mk(32'h5400_0000, HLT, HLT, HLT, 1, 32'd0, 1, 0, 2);
    vecs[9]  = mk(enc_i(6'h08, 0, 1, 16'h77), enc_i(6'h2B, 0, 1, 16'h104),
                  enc_i(6'h23, 0, 3, 16'h100), HLT, 3, 32'h1234, 0, 4, 16);
    vecs[10] = mk(enc_i(6'h08, 0, 1, 16'd1), enc_i(6'h04, 1, 0, 16'd1),
                  enc_i(6'h08, 0, 3, 16'd9), HLT, 3, 32'd9, 0, 4, 14);
    vecs[11] = mk(enc_i(6'h04, 0, 0, 16'd1), enc_i(6'h08, 0, 3, 16'd9), HLT, HLT,
                  3, 32'd0, 0, 2, 6);

    // Reset values and first request at RESET_PC.
    load_a(vecs[0]);
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_status", {halted, illegal, retired}, 0);
    chk("rst_counters", {cycle_cnt, instret_cnt}, 0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("first_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    rst_a = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      load_a(v);
      reset_a();
      run_a(300, 1'b0, n_ret, fcyc);
      xreq = 0;
      repeat (4) begin
        @(negedge clk);
        if (mem_req) xreq++;
      end
      chk($sformatf("v%0d_reg", i), u_dut_a.u_rf.regs_q[v.reg_idx], v.reg_val);
      chk($sformatf("v%0d_halted", i), halted, 1);
      chk($sformatf("v%0d_illegal", i), illegal, v.exp_ill);
      chk($sformatf("v%0d_instret", i), instret_cnt, v.exp_ir);
      chk($sformatf("v%0d_retire_pulses", i), n_ret, v.exp_ir);
      chk($sformatf("v%0d_cycles", i), cycle_cnt, v.exp_cyc);
      chk($sformatf("v%0d_req_after_halt", i), xreq, 0);
    end

    // lw with three wait cycles per access.
    v = mk(enc_i(6'h23, 0, 4, 16'd8), HLT, HLT, HLT, 0, 0, 0, 0, 0);
    load_a(v);
    wait_n = 3;
    reset_a();
    run_a(300, 1'b1, n_ret, fcyc);
    chk("ws_r4", u_dut_a.u_rf.regs_q[4], 32'hDEAD_BEEF);
    chk("ws_lw_wb_cycle", fcyc, 10);
    chk("ws_total_cycles", cycle_cnt, 17);
    chk("ws_instret", instret_cnt, 2);

    // Reset in the middle of a waiting store.
    v = mk(enc_i(6'h08, 0, 1, 16'h55), enc_i(6'h2B, 0, 1, 16'h20), HLT, HLT, 0, 0, 0, 0, 0);
    load_a(v);
    reset_a();
    for (int c = 0; c < 60 && !mem_we; c++) @(negedge clk);
    chk("sw_drive", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h20, 32'h55});
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("sw_abort", {mem_req, mem_we}, 0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("sw_restart", {mem_req, mem_addr}, {1'b1, 32'h40});
    chk("sw_restart_cnt", {cycle_cnt, instret_cnt}, 0);
    wait_n = 0;

    // beq r1,r1,-1 spins at the same PC.
    v = mk(enc_i(6'h04, 1, 1, 16'hFFFF), HLT, HLT, HLT, 0, 0, 0, 0, 0);
    load_a(v);
    reset_a();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req) chk("loop_fetch_addr", mem_addr, 32'h40);
    end
    chk("loop_instret", instret_cnt, 10);
    chk("loop_not_halted", halted, 0);

    // j 0x100 lands at 0x400.
    v = mk({6'b000010, 26'h100}, HLT, HLT, HLT, 0, 0, 0, 0, 0);
    load_a(v);
    mem[256] = HLT;
    reset_a();
    repeat (3) @(negedge clk);
    chk("j_fetch", {mem_req, mem_addr}, {1'b1, 32'h400});
    run_a(100, 1'b0, n_ret, fcyc);
    chk("j_instret", instret_cnt, 2);

    // 64-bit core with 16 registers.
    for (int k = 0; k < 64; k++) mem_b[k] = 32'h0;
    mem_b[0] = enc_i(6'h08, 0, 1, 16'hFFFF);
    mem_b[1] = enc_i(6'h08, 0, 2, 16'd1);
    mem_b[2] = enc_r(1, 2, 3, 6'h2A);
    mem_b[3] = enc_r(1, 2, 4, 6'h20);
    mem_b[4] = enc_i(6'h08, 0, 5'd22, 16'd3);
    mem_b[5] = enc_r(5'd17, 2, 5'd23, 6'h2A);
    mem_b[6] = HLT;
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 200 && !halted_b; c++) @(negedge clk);
    chk("b_halted", {halted_b, illegal_b, we_b}, 3'b100);
    chk("b_r1_sext", u_dut_b.u_rf.regs_q[1], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_slt", u_dut_b.u_rf.regs_q[3], 64'd1);
    chk("b_add_wrap", u_dut_b.u_rf.regs_q[4], 64'd0);
    chk("b_rt_low_bits", u_dut_b.u_rf.regs_q[6], 64'd3);
    chk("b_rs_rd_low_bits", u_dut_b.u_rf.regs_q[7], 64'd1);
    chk("b_instret", inst_b, 64'd7);
    chk("b_cycles", cyc_b, 64'd27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
